// File: rtl/mdu_issue_queue_if.sv
// Request, result and MDU start/busy signals of mdu_issue_queue.
// The slave side is the queue; the master side is the pipeline plus MDU.
interface mdu_issue_queue_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_busy;
    logic [31:0] mdu_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        idle;
    logic        err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, mdu_busy, mdu_out, res_ready,
        output in_ready, mdu_start, mdu_op, mdu_a, mdu_b, res_valid, res_data, idle, err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, mdu_busy, mdu_out, res_ready,
        input  in_ready, mdu_start, mdu_op, mdu_a, mdu_b, res_valid, res_data, idle, err
    );
endinterface

// File: rtl/mdu_issue_queue.sv
// FIFO of multiply/divide-class ops issued one at a time to the MDU.
// mfhi/mflo results are returned through a one-entry valid/ready register.
module mdu_issue_queue #(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    mdu_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, CHK, RUN} state_t;

    logic [3:0]  q_op [DEPTH];
    logic [31:0] q_a  [DEPTH];
    logic [31:0] q_b  [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;

    state_t      state, state_nxt;
    logic        start, res_load, chk_fail, err_q;
    logic [3:0]  op_o;
    logic [31:0] a_o, b_o;
    logic [3:0]  head_op;
    logic [31:0] head_a, head_b;
    logic        res_valid_q;
    logic [31:0] res_data_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push    = bus.in_valid && !full;
    assign head_op = q_op[rd_ptr[AW-1:0]];
    assign head_a  = q_a[rd_ptr[AW-1:0]];
    assign head_b  = q_b[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr[AW-1:0]] <= bus.in_op;
            q_a[wr_ptr[AW-1:0]]  <= bus.in_a;
            q_b[wr_ptr[AW-1:0]]  <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (chk_fail) err_q <= 1'b1;
        end
    end

    // RUN with busy low behaves exactly like IDLE, so both share the issue decode.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        res_load  = 1'b0;
        start     = 1'b0;
        chk_fail  = 1'b0;
        op_o      = 4'd0;
        a_o       = 32'd0;
        b_o       = 32'd0;
        case (state)
            CHK: begin
                if (bus.mdu_busy) begin
                    state_nxt = RUN;
                end else begin
                    chk_fail  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDLE, RUN: begin
                if (!bus.mdu_busy) begin
                    state_nxt = IDLE;
                    if (!empty) begin
                        case (head_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                start     = 1'b1;
                                op_o      = head_op;
                                a_o       = head_a;
                                b_o       = head_b;
                                pop       = 1'b1;
                                state_nxt = CHK;
                            end
                            OP_MTHI, OP_MTLO: begin
                                op_o = head_op;
                                a_o  = head_a;
                                b_o  = head_b;
                                pop  = 1'b1;
                            end
                            OP_MFHI, OP_MFLO: begin
                                // A read only issues if its result has somewhere to land.
                                if (!res_valid_q || bus.res_ready) begin
                                    op_o     = head_op;
                                    a_o      = head_a;
                                    b_o      = head_b;
                                    pop      = 1'b1;
                                    res_load = 1'b1;
                                end
                            end
                            default: pop = 1'b1;
                        endcase
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
        end else if (res_load) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.mdu_out;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.mdu_start = start;
    assign bus.mdu_op    = op_o;
    assign bus.mdu_a     = a_o;
    assign bus.mdu_b     = b_o;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.idle      = empty && (state == IDLE) && !bus.mdu_busy;
    // A missing busy is flagged already in the CHK cycle, then held sticky.
    assign bus.err       = err_q | chk_fail;
endmodule

// File: tb/tb_mdu_issue_queue.sv
// Scoreboard bench for mdu_issue_queue with a behavioural MDU (5/10-cycle busy).
module tb_mdu_issue_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_issue_queue_if bus();
    mdu_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_start = -1;
    int t_res = -1;
    int start_busy_viol = 0;
    logic saw_full = 1'b0;
    logic stub_dead = 1'b0;
    logic [31:0] exp_q[$];
    int issue_log[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int qa, qb;
        sa = $signed(a);
        sb = $signed(b);
        qa = int'(a);
        qb = int'(b);
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: return (b == 0) ? 64'd0 : {32'(qa % qb), 32'(qa / qb)};
            4'd4: return (b == 0) ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural MDU: busy from the edge after start, HI/LO readable once busy drops.
    logic [31:0] m_hi, m_lo;
    int m_cnt;
    assign bus.mdu_busy = (m_cnt != 0);
    assign bus.mdu_out  = (bus.mdu_op == 4'd5) ? m_hi : (bus.mdu_op == 4'd6) ? m_lo : 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
        end else begin
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            if (bus.mdu_start) begin
                {m_hi, m_lo} <= calc(bus.mdu_op, bus.mdu_a, bus.mdu_b);
                if (!stub_dead) m_cnt <= (bus.mdu_op >= 4'd3) ? 10 : 5;
            end else if (bus.mdu_op == 4'd7) begin
                m_hi <= bus.mdu_a;
            end else if (bus.mdu_op == 4'd8) begin
                m_lo <= bus.mdu_a;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.mdu_start && bus.mdu_busy) start_busy_viol++;
            if (bus.mdu_start) t_start = cyc;
            if (bus.res_valid && t_res < 0) t_res = cyc;
            if (bus.mdu_op != 4'd0) issue_log.push_back(cyc);
            if (bus.res_valid && bus.res_ready) begin
                chk("res_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("res_data", bus.res_data, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            saw_full = 1'b1;
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("push_timeout", 32'(bus.in_ready), 32'd1);
        else if (op == 4'd5 || op == 4'd6) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 4'd0;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (!(bus.idle && !bus.res_valid && exp_q.size() == 0) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("drain_timeout", 32'(bus.idle), 32'd1);
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!bus.mdu_start && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("start_seen", 32'(bus.mdu_start), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({pfx, "_idle"}, 32'(bus.idle), 32'd1);
        chk({pfx, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({pfx, "_mdu_start"}, 32'(bus.mdu_start), 32'd0);
        chk({pfx, "_mdu_op"}, 32'(bus.mdu_op), 32'd0);
        chk({pfx, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("rst");
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_mdu_a", bus.mdu_a, 32'd0);

        // signed mult then both reads; mfhi result lands 7 cycles after start
        @(posedge clk);
        #1;
        t_start = -1;
        t_res = -1;
        push(4'd1, 32'hFFFFFFFF, 32'h00000002, 32'd0);
        push(4'd5, 32'd0, 32'd0, 32'hFFFFFFFF);
        push(4'd6, 32'd0, 32'd0, 32'hFFFFFFFE);
        wait_drain();
        chk("mult_latency", 32'(t_res - t_start), 32'd7);

        // signed and unsigned divide, no start while busy
        @(posedge clk);
        #1;
        push(4'd3, 32'hFFFFFFF9, 32'd2, 32'd0);
        push(4'd6, 32'd0, 32'd0, 32'hFFFFFFFD);
        push(4'd5, 32'd0, 32'd0, 32'hFFFFFFFF);
        push(4'd4, 32'hFFFFFFF9, 32'd2, 32'd0);
        push(4'd6, 32'd0, 32'd0, 32'h7FFFFFFC);
        wait_drain();
        chk("start_while_busy", 32'(start_busy_viol), 32'd0);

        // mthi/mtlo/mfhi/mflo issue on consecutive cycles
        @(posedge clk);
        #1;
        issue_log.delete();
        push(4'd7, 32'h12345678, 32'd0, 32'd0);
        push(4'd8, 32'h9ABCDEF0, 32'd0, 32'd0);
        push(4'd5, 32'd0, 32'd0, 32'h12345678);
        push(4'd6, 32'd0, 32'd0, 32'h9ABCDEF0);
        wait_drain();
        chk("issue_count", 32'(issue_log.size()), 32'd4);
        if (issue_log.size() == 4)
            for (int i = 0; i < 3; i++) chk("issue_gap", 32'(issue_log[i+1] - issue_log[i]), 32'd1);

        // back-pressure: full FIFO refuses, held read drives nothing, nothing lost
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        saw_full = 1'b0;
        push(4'd3, 32'hFFFFFFF9, 32'd2, 32'd0);
        for (int i = 0; i <= DEPTH; i++)
            push((i % 2 == 0) ? 4'd6 : 4'd5, 32'd0, 32'd0, (i % 2 == 0) ? 32'hFFFFFFFD : 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        chk("full_seen", 32'(saw_full), 32'd1);
        chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
        chk("hold_res_data", bus.res_data, 32'hFFFFFFFD);
        chk("hold_mdu_op", 32'(bus.mdu_op), 32'd0);
        chk("hold_idle", 32'(bus.idle), 32'd0);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // dead MDU: err in CHK cycle, back to IDLE, sticky until reset
        @(posedge clk);
        #1;
        stub_dead = 1'b1;
        push(4'd1, 32'd3, 32'd4, 32'd0);
        wait_start();
        @(negedge clk);
        chk("err_in_chk", 32'(bus.err), 32'd1);
        @(negedge clk);
        chk("err_back_idle", 32'(bus.idle), 32'd1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bus.err), 32'd1);
        stub_dead = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("err_cleared", 32'(bus.err), 32'd0);

        // reset during RUN of a div with three entries queued
        @(posedge clk);
        #1;
        push(4'd3, 32'd100, 32'd7, 32'd0);
        push(4'd5, 32'd0, 32'd0, 32'd2);
        push(4'd6, 32'd0, 32'd0, 32'd14);
        push(4'd7, 32'h55555555, 32'd0, 32'd0);
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.mdu_busy), 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        chk_reset_state("midrst");
        repeat (15) @(negedge clk);
        chk("lost_res_valid", 32'(bus.res_valid), 32'd0);
        chk("lost_idle", 32'(bus.idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_issue_queue.md
# mdu_issue_queue

Buffers multiply/divide-class instructions from the E stage in a small FIFO and issues them one at a time to the MDU over its start/MDUOp/busy protocol. Result reads (mfhi/mflo) are returned through a one-entry valid/ready result register. The pipeline can therefore hand off MDU work without decoding busy itself. A built-in checker flags MDU handshake violations.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears FIFO, FSM, result register, err
- in_valid  in  1  request present
- in_op  in  4  op code: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- in_a, in_b  in  32  operands (rs, rt)
- in_ready  out  1  = !full; reset value 1
- mdu_start  out  1  start pulse to MDU; reset 0
- mdu_op  out  4  MDUOp to MDU; 0 whenever not issuing; reset 0
- mdu_a, mdu_b  out  32  head operands during issue cycle, else 0; reset 0
- mdu_busy  in  1  MDU busy
- mdu_out  in  32  MDU read data (combinational from mdu_op)
- res_valid  out  1  result register full; reset 0
- res_data  out  32  result; reset 0
- res_ready  in  1  consumer accepts result
- idle  out  1  FIFO empty, FSM IDLE, mdu_busy 0; reset 1
- err  out  1  sticky protocol error; reset 0

## Operation
- Push on in_valid && in_ready. in_ready does not account for a same-cycle pop; a full FIFO refuses a push even while popping.
- Codes 0 and 9–15 are accepted, then popped in IDLE with no MDU activity. Each such drop takes one cycle.
- FSM states:
  - IDLE:
    - Head issues only if FIFO non-empty and mdu_busy = 0.
    - mult/multu/div/divu: mdu_start = 1, mdu_op/a/b = head. Pop, then go to CHK.
    - mthi/mtlo: mdu_op = head, mdu_a = in_a of entry, start 0. Pop, stay IDLE.
    - mfhi/mflo: issue only if !res_valid || res_ready. Drive mdu_op, pop, and load res_data <= mdu_out with res_valid <= 1. Otherwise hold, driving nothing.
  - CHK (1 cycle, no issue):
    - mdu_busy = 1 -> RUN.
    - mdu_busy = 0 -> set err, go to IDLE.
  - RUN:
    - mdu_busy = 1 -> hold, no issue.
    - mdu_busy = 0 -> behave exactly as IDLE this cycle, including issuing, and take IDLE's transition.
- Result register:
  - Clears when res_valid && res_ready and no new load happens that cycle.
  - Load and drain in the same cycle: the new value wins and res_valid stays 1.
- At most one MDU op is outstanding. Program order of all ops is preserved.
- Arithmetic is performed entirely by the MDU. Operands pass unmodified, including divide-by-zero.

## Timing
- A push at the edge closing cycle 0 makes the entry issuable in cycle 1. Minimum latency is 1 cycle; issue decode is combinational from registered state and mdu_busy.
- MDU response:
  - busy rises at the edge after the start cycle.
  - mult/multu: busy high 5 cycles; div/divu: 10 cycles.
  - HI/LO are valid the first cycle busy is 0.
- mult pushed in cycle 0:
  - start in cycle 1; CHK in cycle 2; RUN in cycles 3–6.
  - A queued mfhi issues in cycle 7; res_valid = 1 in cycle 8.
- Back-to-back mthi then mfhi: issued in consecutive cycles. mfhi returns the new value, since the MDU writes HI at the mthi edge.
- Reset mid-op: all outputs return to reset values next cycle and pending entries are lost. The MDU shares reset.
- err stays 1 until reset.

## Test plan
- Push mult A=0xFFFFFFFF B=0x00000002, mfhi, mflo -> results 0xFFFFFFFF then 0xFFFFFFFE; mfhi res_valid rises exactly 7 cycles after the mult start.
- Push div A=0xFFFFFFF9 (−7) B=2, mflo, mfhi, then divu same operands, mflo -> 0xFFFFFFFD, 0xFFFFFFFF, 0x7FFFFFFC; mdu_start never asserted while mdu_busy = 1.
- mthi 0x12345678, mtlo 0x9ABCDEF0, mfhi, mflo with res_ready = 1 -> issued on 4 consecutive cycles; results 0x12345678, 0x9ABCDEF0.
- Hold res_ready = 0, push DEPTH+1 reads behind a div -> in_ready = 0 when full; second read waits until res_ready; no result lost or duplicated.
- Stub MDU that never raises busy, issue mult -> err = 1 in CHK cycle; FSM returns to IDLE; err stays 1 until reset.
- Assert reset during RUN of a div with 3 queued entries -> next cycle in_ready = 1, idle = 1, res_valid = 0, mdu_op = 0, err = 0.
